// File: rtl/uart_rx.sv
// Mid-bit-sampling UART receiver (8N1, LSB first) with input synchroniser,
// framing-error and overrun detection, and a valid/ready output register.
module uart_rx #(
   parameter int unsigned ClksPerBit = 273,
   parameter int unsigned DataBits   = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rx_i,
   output logic [DataBits-1:0] data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                frame_err_o,
   output logic                overrun_o,
   output logic                busy_o
);

   localparam int unsigned CntW = $clog2(ClksPerBit);
   localparam int unsigned IdxW = (DataBits > 1) ? $clog2(DataBits) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

   typedef enum logic [2:0] {
      StWaitHigh,
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [IdxW-1:0]     idx_q;
   logic [DataBits-1:0] shift_q;
   logic                sync1_q;
   logic                rx_s;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         rx_s    <= sync1_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StWaitHigh;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         // A load in StStop below overrides this clear.
         if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end

         unique case (state_q)
            StWaitHigh: begin
               // Need a full bit time of idle line before trusting a falling edge.
               if (!rx_s) begin
                  cnt_q <= '0;
               end else if (cnt_q == CntLast) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StIdle: begin
               if (!rx_s) begin
                  cnt_q   <= '0;
                  busy_o  <= 1'b1;
                  state_q <= StStart;
               end
            end

            StStart: begin
               if (cnt_q == CntHalf) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     busy_o  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     idx_q   <= '0;
                     state_q <= StData;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StData: begin
               if (cnt_q == CntLast) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[DataBits-1:1]};
                  if (idx_q == IdxLast) begin
                     state_q <= StStop;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StStop: begin
               if (cnt_q == CntLast) begin
                  cnt_q  <= '0;
                  busy_o <= 1'b0;
                  if (rx_s) begin
                     state_q <= StIdle;
                     if (!valid_o || ready_i) begin
                        data_o  <= shift_q;
                        valid_o <= 1'b1;
                     end else begin
                        overrun_o <= 1'b1;
                     end
                  end else begin
                     frame_err_o <= 1'b1;
                     state_q     <= StWaitHigh;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: state_q <= StWaitHigh;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters: timing, backpressure,
// framing error, glitch rejection and mid-frame reset.
module tb_uart_rx;

   localparam int Cpb  = 273;
   localparam int Half = Cpb / 2;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Event monitor, sampled on the falling edge
   int         rise_cnt  = 0;
   int         vhigh_cnt = 0;
   int         ferr_cnt  = 0;
   int         ovr_cnt   = 0;
   int         busy_cnt  = 0;
   int         last_rise = 0;
   int         last_ovr  = 0;
   logic [7:0] last_data = '0;
   logic       prev_valid = 1'b0;

   uart_rx #(
      .ClksPerBit(Cpb),
      .DataBits  (8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rx_i       (rx),
      .data_o     (data),
      .valid_o    (valid),
      .ready_i    (ready),
      .frame_err_o(frame_err),
      .overrun_o  (overrun),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_valid <= valid;
      if (valid && !prev_valid) begin
         rise_cnt  <= rise_cnt + 1;
         last_rise <= cyc;
         last_data <= data;
      end
      if (valid === 1'b1) vhigh_cnt <= vhigh_cnt + 1;
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (overrun === 1'b1) begin
         ovr_cnt  <= ovr_cnt + 1;
         last_ovr <= cyc;
      end
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; e0 is the first edge that samples the start bit.
   // With pulse_rdy, ready is raised only for the stop-sample edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse_rdy,
                             output int e0);
      rx = 1'b0;
      e0 = cyc + 1;
      repeat (Cpb) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(posedge clk);
         #1;
      end
      rx = stop;
      for (int c = 0; c < Cpb; c++) begin
         if (pulse_rdy) ready = (c == Half + 2);
         @(posedge clk);
         #1;
      end
      if (pulse_rdy) ready = 1'b0;
   endtask

   int e0a, e0b;
   int b_rise, b_vhigh, b_ferr, b_ovr, b_busy;

   task automatic snap();
      b_rise  = rise_cnt;
      b_vhigh = vhigh_cnt;
      b_ferr  = ferr_cnt;
      b_ovr   = ovr_cnt;
      b_busy  = busy_cnt;
   endtask

   initial begin
      rx    = 1'b1;
      rst_n = 1'b0;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_data", 32'(data), 32'd0);
      chk("reset_ferr", 32'(frame_err), 32'd0);
      chk("reset_ovr", 32'(overrun), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
      #1;

      // Single byte, consumer always ready
      ready = 1'b1;
      snap();
      send_frame(8'hA5, 1'b1, 1'b0, e0a);
      repeat (5) @(posedge clk);
      #1;
      chk("single_rises", 32'(rise_cnt - b_rise), 32'd1);
      chk("single_vcycles", 32'(vhigh_cnt - b_vhigh), 32'd1);
      chk("single_latency", 32'(last_rise - e0a), 32'd2595);
      chk("single_data", 32'(last_data), 32'hA5);
      chk("single_errs", 32'((ferr_cnt - b_ferr) + (ovr_cnt - b_ovr)), 32'd0);

      // Back-to-back with backpressure
      ready = 1'b0;
      snap();
      send_frame(8'h3C, 1'b1, 1'b0, e0a);
      send_frame(8'hC3, 1'b1, 1'b0, e0b);
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_data", 32'(data), 32'h3C);
      chk("bp_ovr_count", 32'(ovr_cnt - b_ovr), 32'd1);
      chk("bp_ovr_time", 32'(last_ovr - e0b), 32'd2595);
      chk("bp_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk("bp_accept", 32'(valid), 32'd0);

      // Accept and load on the same edge
      snap();
      send_frame(8'h5A, 1'b1, 1'b0, e0a);
      send_frame(8'h96, 1'b1, 1'b1, e0b);
      chk("sim_valid", 32'(valid), 32'd1);
      chk("sim_data", 32'(data), 32'h96);
      chk("sim_ovr", 32'(ovr_cnt - b_ovr), 32'd0);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk("sim_drain", 32'(valid), 32'd0);

      // Framing error, line held low, then a clean byte left pending
      snap();
      send_frame(8'h55, 1'b0, 1'b0, e0a);
      chk("fe_pulse", 32'(ferr_cnt - b_ferr), 32'd1);
      b_busy = busy_cnt;
      repeat (2 * Cpb) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("fe_no_false_start", 32'(busy_cnt - b_busy), 32'd0);
      chk("fe_no_valid", 32'(rise_cnt - b_rise), 32'd0);
      send_frame(8'h12, 1'b1, 1'b0, e0a);
      chk("fe_next_valid", 32'(valid), 32'd1);
      chk("fe_next_data", 32'(data), 32'h12);
      chk("fe_single_err", 32'(ferr_cnt - b_ferr), 32'd1);

      // Glitch rejection while 0x12 is still pending
      snap();
      rx  = 1'b0;
      e0a = cyc + 1;
      repeat (50) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      chk("gl_busy_mid", 32'(busy), 32'd1);
      repeat (79) @(posedge clk);
      #1;
      chk("gl_busy_clear", 32'(busy), 32'd0);
      repeat (300) @(posedge clk);
      #1;
      chk("gl_no_pulses", 32'((rise_cnt - b_rise) + (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr)),
          32'd0);
      chk("gl_data_kept", 32'({valid, data}), 32'h112);

      // Reset during data bit 3 of 0xFF
      rx = 1'b0;
      repeat (Cpb) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (3 * Cpb + 100) @(posedge clk);
      #1;
      chk("rst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_pulses", 32'({frame_err, overrun}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      snap();
      repeat (5 * Cpb + 300) @(posedge clk);
      #1;
      chk("rst_tail_ignored", 32'((rise_cnt - b_rise) + (busy_cnt - b_busy)), 32'd0);
      ready = 1'b1;
      send_frame(8'h81, 1'b1, 1'b0, e0a);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_next_rise", 32'(rise_cnt - b_rise), 32'd1);
      chk("rst_next_data", 32'(last_data), 32'h81);
      chk("rst_next_errs", 32'((ferr_cnt - b_ferr) + (ovr_cnt - b_ovr)), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling-free, mid-bit-sampling UART receiver. It converts the asynchronous `rx_i` pin into a byte stream with a valid/ready handshake. It sits directly upstream of the ALU command logic in the `uart_alu` datapath and runs in the 31.5 MHz PLL domain. It performs its own input synchronisation and detects both framing errors and overruns.

## Interface
- `ClksPerBit`, default 273: clock cycles per bit. 31.5 MHz / 115200 ≈ 273. Legal range ≥ 8.
- `DataBits`, default 8: data bits per frame. 8N1 format, LSB first.
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_o`  out  DataBits  received byte; stable while `valid_o` is high.
- `valid_o`  out  1  byte available; held until accepted.
- `ready_i`  in  1  consumer accepts `data_o` when `valid_o && ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: a complete byte was dropped because the output register was still full.
- `busy_o`  out  1  high in START, DATA and STOP states.

## Operation
- **Synchroniser.** Two flops on `rx_i` produce `rx_s`. Both flops reset to 1. The FSM uses only `rx_s`.
- **Counters.** `H = ClksPerBit/2` (integer division). A bit counter counts `0..ClksPerBit-1`. A bit index counts `0..DataBits-1`.
- **FSM states.** WAIT_HIGH, IDLE, START, DATA, STOP.
  - **WAIT_HIGH** (reset state): exits to IDLE once `rx_s` has been 1 for `ClksPerBit` consecutive cycles. Any 0 restarts the count. This prevents a mid-frame reset or a break from producing false starts.
  - **IDLE:** `rx_s == 0` → START, counter cleared.
  - **START:** at counter `H-1`, sample `rx_s`.
    - 0 → DATA, counter cleared.
    - 1 → IDLE (glitch rejected, no pulse).
  - **DATA:** at counter `ClksPerBit-1`, shift `rx_s` into the MSB of the shift register (right shift, so LSB arrives first). After bit `DataBits-1` → STOP.
  - **STOP:** at counter `ClksPerBit-1`, sample `rx_s`.
    - 1 → frame good → IDLE.
    - 0 → `frame_err_o` pulses, byte discarded → WAIT_HIGH.
- **Output register, on a good frame:**
  - If `valid_o == 0`, or `valid_o && ready_i` in the same cycle: load `data_o` and set `valid_o`. A simultaneous accept and load is not an overrun.
  - Otherwise keep the old byte and pulse `overrun_o`. The new byte is lost.
- **Handshake.** `valid_o` clears on the cycle after `valid_o && ready_i`, unless a new byte loads in that same cycle. `data_o` never changes while `valid_o` is high and unaccepted.
- **Reset.** Synchronous reset at any point, including mid-frame:
  - State → WAIT_HIGH.
  - `data_o`=0, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
  - Shift register and counters → 0.
  - Synchroniser → 1.

## Timing
- Let edge e0 be the first clock edge that samples `rx_i` low in IDLE.
  - `rx_s` is low after e1.
  - The FSM enters START after e2.
- Sample points:
  - Start bit sampled at e2+H.
  - Data bit k (k=0..DataBits-1) sampled at e2+H+(k+1)·ClksPerBit.
  - Stop bit sampled at e2+H+(DataBits+1)·ClksPerBit.
- `valid_o`, `frame_err_o` or `overrun_o` is visible after the stop-sample edge. With defaults that is e0+2595.
- The FSM is back in IDLE immediately after the stop sample. A start bit arriving right after the stop bit's midpoint is accepted, which tolerates back-to-back frames with ±4% baud error.
- `busy_o` is high from e2 through the stop-sample edge.
- Throughput: one byte per `(DataBits+2)·ClksPerBit` cycles.

## Test plan
- **Single byte.** Reset, hold `rx_i`=1 for 300 cycles, send 0xA5 at 273 clk/bit, `ready_i`=1.
  - Required: `valid_o` high for exactly 1 cycle, first high 2595 edges after e0, `data_o`=0xA5.
  - Required: no error pulses.
- **Back-to-back with backpressure.** Send 0x3C then 0xC3 with no idle gap, `ready_i`=0 throughout.
  - Required: `data_o` stays 0x3C and `overrun_o` pulses once at the second stop sample.
  - Then raise `ready_i` for 1 cycle: `valid_o` drops.
- **Simultaneous accept and load.** Assert `ready_i` exactly on the second byte's stop-sample cycle.
  - Required: `data_o`=second byte, `valid_o` stays high, `overrun_o`=0.
- **Framing error.** Send 0x55 with the stop bit driven 0, then hold the line low for 2 bit times, then release and send 0x12.
  - Required: `frame_err_o` pulses once, no `valid_o` for 0x55.
  - Required: no false start while the line is low; 0x12 is received correctly.
- **Glitch rejection.** Pulse `rx_i` low for 50 cycles.
  - Required: FSM returns to IDLE, `busy_o` low again by e2+H+1, no outputs asserted.
- **Reset mid-frame.** Assert `rst_ni`=0 for 1 cycle during data bit 3 of 0xFF, then continue the frame.
  - Required: all outputs 0 at the following edge and no byte produced from the tail of the frame.
  - Required: the next clean frame 0x81 is received correctly.
